// File: rtl/ysyx_23060136_wbu_csr_commit_pkg.sv
// Shared CSR definitions for the WBU commit path: op/state enums, CSR indices, mstatus fields.
package ysyx_23060136_CSR_PKG;

    localparam int CSR_IDX_W = 3;
    localparam int CSR_NUM   = 6;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRAP2 = 1'b1
    } commit_state_t;

    localparam logic [CSR_IDX_W-1:0] CSR_MSTATUS   = 3'd0;
    localparam logic [CSR_IDX_W-1:0] CSR_MTVEC     = 3'd1;
    localparam logic [CSR_IDX_W-1:0] CSR_MEPC      = 3'd2;
    localparam logic [CSR_IDX_W-1:0] CSR_MCAUSE    = 3'd3;
    localparam logic [CSR_IDX_W-1:0] CSR_MVENDORID = 3'd4;
    localparam logic [CSR_IDX_W-1:0] CSR_MARCHID   = 3'd5;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/ysyx_23060136_wbu_csr_commit_alu.sv
// Combinational read-modify-write value for csrrw/csrrs/csrrc.
module ysyx_23060136_wbu_csr_alu
    import ysyx_23060136_CSR_PKG::*;
#(
    parameter int BITS_W = 64
) (
    input  csr_op_t           op,
    input  logic [BITS_W-1:0] old_val,
    input  logic [BITS_W-1:0] src_val,
    output logic [BITS_W-1:0] new_val
);

    // Select the new CSR value by op
    always_comb begin
        new_val = old_val;
        case (op)
            CSR_RW:  new_val = src_val;
            CSR_RS:  new_val = old_val | src_val;
            CSR_RC:  new_val = old_val & ~src_val;
            default: new_val = old_val;
        endcase
    end

endmodule

// File: rtl/ysyx_23060136_wbu_csr_commit.sv
// WBU-side CSR writer: two write channels, ecall/mret sequencing, PC redirect, rd writeback.
// Optional read-only protection of mvendorid/marchid under YSYX_23060136_CSR_RO_CHECK_EN.
module ysyx_23060136_wbu_csr_commit
    import ysyx_23060136_CSR_PKG::*;
#(
    parameter int               BITS_W       = 64,
    parameter int               CSR_W        = 3,
    parameter logic [BITS_W-1:0] MCAUSE_ECALL = 64'd11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WBU_valid,
    output logic              WBU_ready,
    input  logic [1:0]        csr_op,
    input  logic              is_ecall,
    input  logic              is_mret,
    input  logic [CSR_W-1:0]  csr_idx,
    input  logic [BITS_W-1:0] csr_old,
    input  logic [BITS_W-1:0] csr_src,
    input  logic              src_is_zero,
    input  logic [BITS_W-1:0] pc,
    input  logic [BITS_W-1:0] mstatus_in,
    input  logic [BITS_W-1:0] mtvec_in,
    input  logic [BITS_W-1:0] mepc_in,
    output logic              CSRWr_1,
    output logic              CSRWr_2,
    output logic [CSR_W-1:0]  WBU_csr_rd_1,
    output logic [CSR_W-1:0]  WBU_csr_rd_2,
    output logic [BITS_W-1:0] csr_busW_1,
    output logic [BITS_W-1:0] csr_busW_2,
    output logic              rd_valid,
    output logic [BITS_W-1:0] rd_data,
    output logic              redirect_valid,
    output logic [BITS_W-1:0] redirect_pc,
    output logic              ro_err
);

    function automatic logic [BITS_W-1:0] mstatus_trap(input logic [BITS_W-1:0] m);
        logic [BITS_W-1:0] r;
        r = m;
        r[MSTATUS_MPIE] = m[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [BITS_W-1:0] mstatus_ret(input logic [BITS_W-1:0] m);
        logic [BITS_W-1:0] r;
        r = m;
        r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    commit_state_t     state_q, state_d;
    logic              wr1_q, wr1_d, wr2_q, wr2_d;
    logic [CSR_W-1:0]  rd1_q, rd1_d, rd2_q, rd2_d;
    logic [BITS_W-1:0] bus1_q, bus1_d, bus2_q, bus2_d;
    logic              rd_valid_q, rd_valid_d;
    logic [BITS_W-1:0] rd_data_q, rd_data_d;
    logic              redir_q, redir_d;
    logic [BITS_W-1:0] redir_pc_q, redir_pc_d;
    logic              ro_err_q, ro_err_d;
    logic [BITS_W-1:0] mstatus_cap_q, mstatus_cap_d;
    logic [BITS_W-1:0] mtvec_cap_q, mtvec_cap_d;

    logic              accept_s;
    logic              idx_in_range_s;
    logic              ro_hit_s;
    logic              csr_wr_ok_s;
    logic [BITS_W-1:0] alu_new_s;
    csr_op_t           op_s;

    assign op_s           = csr_op_t'(csr_op);
    assign accept_s       = WBU_valid && (state_q == ST_IDLE);
    assign idx_in_range_s = (csr_idx < CSR_W'(CSR_NUM));

`ifdef YSYX_23060136_CSR_RO_CHECK_EN
    assign ro_hit_s = (csr_idx == CSR_W'(CSR_MVENDORID)) || (csr_idx == CSR_W'(CSR_MARCHID));
`else
    assign ro_hit_s = 1'b0;
`endif

    // RS/RC with a zero source is a pure read and must not write
    assign csr_wr_ok_s = ((op_s == CSR_RW) || !src_is_zero) && idx_in_range_s && !ro_hit_s;

    ysyx_23060136_wbu_csr_alu #(.BITS_W(BITS_W)) u_alu (
        .op      (op_s),
        .old_val (csr_old),
        .src_val (csr_src),
        .new_val (alu_new_s)
    );

    // Next-state and next-output computation for the commit FSM
    always_comb begin
        state_d       = state_q;
        wr1_d         = 1'b0;
        wr2_d         = 1'b0;
        rd1_d         = rd1_q;
        rd2_d         = rd2_q;
        bus1_d        = bus1_q;
        bus2_d        = bus2_q;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        redir_d       = 1'b0;
        redir_pc_d    = redir_pc_q;
        ro_err_d      = 1'b0;
        mstatus_cap_d = mstatus_cap_q;
        mtvec_cap_d   = mtvec_cap_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_ecall) begin
                        wr1_d         = 1'b1;
                        rd1_d         = CSR_W'(CSR_MEPC);
                        bus1_d        = pc;
                        wr2_d         = 1'b1;
                        rd2_d         = CSR_W'(CSR_MCAUSE);
                        bus2_d        = MCAUSE_ECALL;
                        mstatus_cap_d = mstatus_in;
                        mtvec_cap_d   = {mtvec_in[BITS_W-1:2], 2'b00};
                        state_d       = ST_TRAP2;
                    end else if (is_mret) begin
                        wr1_d      = 1'b1;
                        rd1_d      = CSR_W'(CSR_MSTATUS);
                        bus1_d     = mstatus_ret(mstatus_in);
                        redir_d    = 1'b1;
                        redir_pc_d = mepc_in;
                    end else if (op_s != CSR_NONE) begin
                        wr1_d      = csr_wr_ok_s;
                        rd1_d      = csr_idx;
                        bus1_d     = alu_new_s;
                        rd_valid_d = 1'b1;
                        rd_data_d  = csr_old;
                        ro_err_d   = ro_hit_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRAP2: begin
                wr1_d      = 1'b1;
                rd1_d      = CSR_W'(CSR_MSTATUS);
                bus1_d     = mstatus_trap(mstatus_cap_q);
                redir_d    = 1'b1;
                redir_pc_d = mtvec_cap_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr1_q         <= 1'b0;
            wr2_q         <= 1'b0;
            rd1_q         <= {CSR_W{1'b0}};
            rd2_q         <= {CSR_W{1'b0}};
            bus1_q        <= {BITS_W{1'b0}};
            bus2_q        <= {BITS_W{1'b0}};
            rd_valid_q    <= 1'b0;
            rd_data_q     <= {BITS_W{1'b0}};
            redir_q       <= 1'b0;
            redir_pc_q    <= {BITS_W{1'b0}};
            ro_err_q      <= 1'b0;
            mstatus_cap_q <= {BITS_W{1'b0}};
            mtvec_cap_q   <= {BITS_W{1'b0}};
        end else begin
            state_q       <= state_d;
            wr1_q         <= wr1_d;
            wr2_q         <= wr2_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            bus1_q        <= bus1_d;
            bus2_q        <= bus2_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            redir_q       <= redir_d;
            redir_pc_q    <= redir_pc_d;
            ro_err_q      <= ro_err_d;
            mstatus_cap_q <= mstatus_cap_d;
            mtvec_cap_q   <= mtvec_cap_d;
        end
    end

    assign WBU_ready      = (state_q == ST_IDLE);
    assign CSRWr_1        = wr1_q;
    assign CSRWr_2        = wr2_q;
    assign WBU_csr_rd_1   = rd1_q;
    assign WBU_csr_rd_2   = rd2_q;
    assign csr_busW_1     = bus1_q;
    assign csr_busW_2     = bus2_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign redirect_valid = redir_q;
    assign redirect_pc    = redir_pc_q;
    assign ro_err         = ro_err_q;

endmodule
